// File: rtl/sha_absorb_packer_pkg.sv
// rtl/sha_absorb_packer_pkg.sv - shared SHA-3 types, FSM states, rate and padding helpers
//
// Contents:
//   lane_t        one 64-bit Keccak lane
//   state_t       5x5 lanes, lane L = 5*y+x at [y][x]
//   fsm_state_e   absorb packer states
//   rate_lanes()  rate lanes for a variant TID
//   pad_block()   OR SHA-3 padding (0x06 ... 0x80) into a block
package sha3_pkg;

  typedef logic [63:0]             lane_t;
  typedef logic [4:0][4:0][63:0]   state_t;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_PADBLK = 2'd2
  } fsm_state_e;

  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_FINAL = 8'h80;

  // 0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512
  function automatic int unsigned rate_lanes(input logic [1:0] tid);
    case (tid)
      2'd0:    return 18;
      2'd1:    return 17;
      2'd2:    return 13;
      default: return 9;
    endcase
  endfunction

  // byte_idx is the flat byte offset of the first free byte after the
  // message; the state flattens with lane L at bits [64L+63:64L].
  function automatic state_t pad_block(input state_t     s,
                                       input int unsigned byte_idx,
                                       input logic [1:0]  tid);
    logic [1599:0] flat;
    logic [10:0]   first_bit;
    logic [10:0]   final_bit;
    flat      = s;
    first_bit = 11'(byte_idx * 8);
    final_bit = 11'((rate_lanes(tid) * 8 - 1) * 8);
    flat[first_bit +: 8] = flat[first_bit +: 8] | PAD_FIRST;
    flat[final_bit +: 8] = flat[final_bit +: 8] | PAD_FINAL;
    return flat;
  endfunction

endpackage

// File: rtl/sha_absorb_packer_if.sv
// rtl/sha_absorb_packer_if.sv - message stream in, packed rate block out
//
// Signals:
//   S_TDATA/S_TVALID/S_TREADY/S_TLAST/S_TID  message word stream
//   Block/Block_valid/Block_ready            packed block handshake
//   Block_last/Block_tid                     block qualifiers
// Modports:
//   slave   the packer (stream sink, block source)
//   master  the environment (stream source, block sink)
interface sha_absorb_packer_if #(
  parameter int DATA_WIDTH = 16
) ();
  import sha3_pkg::*;

  logic [DATA_WIDTH-1:0] S_TDATA;
  logic                  S_TVALID;
  logic                  S_TREADY;
  logic                  S_TLAST;
  logic [1:0]            S_TID;

  state_t                Block;
  logic                  Block_valid;
  logic                  Block_ready;
  logic                  Block_last;
  logic [1:0]            Block_tid;

  modport slave (
    input  S_TDATA, S_TVALID, S_TLAST, S_TID, Block_ready,
    output S_TREADY, Block, Block_valid, Block_last, Block_tid
  );

  modport master (
    output S_TDATA, S_TVALID, S_TLAST, S_TID, Block_ready,
    input  S_TREADY, Block, Block_valid, Block_last, Block_tid
  );

endinterface

// File: rtl/sha_absorb_packer.sv
// rtl/sha_absorb_packer.sv - packs stream words into padded SHA-3 rate blocks
//
// Ports:
//   ACLK     clock, rising edge
//   ARESETn  synchronous active-low reset
//   bus      sha_absorb_packer_if.slave: word stream in, block handshake out
// Parameter:
//   DATA_WIDTH  stream word width, 16/32/64
module sha_absorb_packer
  import sha3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic              ACLK,
  input logic              ARESETn,
  sha_absorb_packer_if.slave bus
);

  localparam int unsigned WORDS_PER_LANE = 64 / DATA_WIDTH;
  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;

  fsm_state_e  state_q;
  state_t      blk_q;
  logic [6:0]  cnt_q;
  logic        in_msg_q;
  logic        pad_pending_q;
  logic        tready_q;
  logic        valid_q;
  logic        last_q;
  logic [1:0]  tid_q;

  logic          accept;
  logic [1:0]    cur_tid;
  logic [6:0]    last_idx;
  logic [10:0]   word_bit;
  int unsigned   pad_byte;
  logic [1599:0] blk_flat;
  state_t        blk_word;
  state_t        blk_padded;

  // tready_q is only ever high in FILL, so it doubles as the FILL qualifier.
  assign accept   = bus.S_TVALID && tready_q;

  // The first word of a message carries the variant; later words reuse the
  // latched copy so a changing S_TID cannot resize a block in flight.
  assign cur_tid  = in_msg_q ? tid_q : bus.S_TID;
  assign last_idx = 7'(rate_lanes(cur_tid) * WORDS_PER_LANE - 1);
  assign word_bit = 11'(cnt_q) * 11'(DATA_WIDTH);
  assign pad_byte = (32'(cnt_q) + 32'd1) * BYTES_PER_WORD;

  // Block with the incoming word merged in, and its padded variant for a
  // message that ends short of the block boundary.
  always_comb begin
    blk_flat                         = blk_q;
    blk_flat[word_bit +: DATA_WIDTH] = bus.S_TDATA;
    blk_word                         = blk_flat;
    blk_padded                       = pad_block(blk_word, pad_byte, cur_tid);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q       <= ST_FILL;
      blk_q         <= '0;
      cnt_q         <= '0;
      in_msg_q      <= 1'b0;
      pad_pending_q <= 1'b0;
      tready_q      <= 1'b0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      tid_q         <= 2'd0;
    end else begin
      case (state_q)
        ST_FILL: begin
          tready_q <= 1'b1;
          if (accept) begin
            if (!in_msg_q) begin
              tid_q <= bus.S_TID;
            end
            if (bus.S_TLAST) begin
              in_msg_q <= 1'b0;
              state_q  <= ST_EMIT;
              valid_q  <= 1'b1;
              tready_q <= 1'b0;
              if (cnt_q == last_idx) begin
                // No room left for padding: it goes into a block of its own.
                blk_q         <= blk_word;
                last_q        <= 1'b0;
                pad_pending_q <= 1'b1;
              end else begin
                blk_q  <= blk_padded;
                last_q <= 1'b1;
              end
            end else begin
              in_msg_q <= 1'b1;
              blk_q    <= blk_word;
              if (cnt_q == last_idx) begin
                state_q  <= ST_EMIT;
                valid_q  <= 1'b1;
                tready_q <= 1'b0;
                last_q   <= 1'b0;
              end else begin
                cnt_q <= cnt_q + 7'd1;
              end
            end
          end
        end

        ST_EMIT: begin
          if (bus.Block_ready) begin
            blk_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            if (pad_pending_q) begin
              state_q <= ST_PADBLK;
            end else begin
              state_q  <= ST_FILL;
              tready_q <= 1'b1;
            end
          end
        end

        ST_PADBLK: begin
          blk_q         <= pad_block('0, 0, tid_q);
          last_q        <= 1'b1;
          pad_pending_q <= 1'b0;
          valid_q       <= 1'b1;
          state_q       <= ST_EMIT;
        end

        default: begin
          state_q  <= ST_FILL;
          tready_q <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.S_TREADY    = tready_q;
  assign bus.Block       = blk_q;
  assign bus.Block_valid = valid_q;
  assign bus.Block_last  = last_q;
  assign bus.Block_tid   = tid_q;

endmodule

// File: doc/sha_absorb_packer.md
# sha_absorb_packer

Ingress deserializer for the SHA-3 datapath: accepts message words over an AXI-Stream slave, packs them into a 5×5×64 Keccak rate block sized by the variant on TID, applies SHA-3 padding on TLAST, and hands complete blocks to the permutation core over a valid/ready handshake. It is the input-side counterpart of the output serializer. That serializer streams the 1600-bit state out as DATA_WIDTH words with Last. This block performs the reverse conversion at the front of the core.

## Interface
- DATA_WIDTH, 16, stream word width; legal values 16, 32, 64 (must divide 64)
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  reset, synchronous, active-low
- S_TDATA  in  DATA_WIDTH  message word
- S_TVALID  in  1  word valid
- S_TREADY  out  1  word accepted when S_TVALID && S_TREADY
- S_TLAST  in  1  final word of message
- S_TID  in  2  variant: 0=SHA3-224, 1=256, 2=384, 3=512
- Block  out  [4:0][4:0][63:0]  packed state block; lane L = 5*y+x at Block[y][x]
- Block_valid  out  1  Block holds a complete block
- Block_ready  in  1  core accepts Block when Block_valid && Block_ready
- Block_last  out  1  final (padded) block of the message
- Block_tid  out  2  TID latched at the first word of the message

## Operation
- Rate R by variant: 1152, 1088, 832, 576 bits (18, 17, 13, 9 lanes). Words per block W = R/DATA_WIDTH.
- Word k of a block goes to lane k/(64/DATA_WIDTH), bits [DW*(j+1)-1:DW*j] with j = k mod (64/DATA_WIDTH). Bytes inside a lane are little-endian: byte b is bits [8b+7:8b]. Capacity lanes are always zero.
- TID is latched on the first accepted word of each message. S_TID on later words of the same message is ignored.
- Messages are word-granular. Empty messages are not supported.
- States:
  - FILL: S_TREADY=1; store each accepted word at index cnt and increment cnt.
    - Accept with cnt==W-1 and !S_TLAST → EMIT, Block_last=0.
    - Accept with S_TLAST and cnt<W-1 → OR 0x06 into the first byte of word cnt+1, OR 0x80 into the last rate byte (lane R/64-1, byte 7), then EMIT with Block_last=1.
    - Accept with S_TLAST and cnt==W-1 → EMIT with Block_last=0 and pad_pending=1.
  - EMIT: S_TREADY=0; Block_valid=1 and Block stable. On Block_ready:
    - Clear the register and set cnt=0.
    - If pad_pending, go to PADBLK; otherwise go to FILL.
  - PADBLK: build a block with 0x06 at lane 0 byte 0 and 0x80 at the last rate byte, set Block_last=1, then go to EMIT with pad_pending=0.
- Because DATA_WIDTH ≥ 16, the 0x06 and 0x80 pad bytes never share a byte.

## Timing
- Reset values (ARESETn=0 on a clock edge): S_TREADY=0, Block_valid=0, Block_last=0, Block_tid=0, Block=0, cnt=0, pad_pending=0, state=FILL.
- S_TREADY=1 from the first cycle after reset is released.
- Throughput: one word per cycle in FILL.
- Block_valid rises on the cycle after the edge that accepts the final word of a block.
- Every block costs at least one EMIT cycle with S_TREADY=0. PADBLK adds one more cycle.
- Block_valid, once asserted, holds with Block, Block_last and Block_tid unchanged until Block_ready.
- Block_ready while Block_valid=0 has no effect.
- Reset mid-message or mid-EMIT discards all partial and pending data, including any pending pad block.

## Structure
- Shared package sha3_pkg holds:
  - lane_t (logic [63:0]) and state_t (logic [4:0][4:0][63:0])
  - the FSM state enum
  - function rate_lanes(tid) returning 18/17/13/9
- No sub-module. The pad logic is a package function pad_block(state_t, word_idx, tid), reused by PADBLK.

## Test plan
- DW=16, TID=1, one word 0x6261 with TLAST → one block.
  - Lane0 = 0x0000_0000_0006_6261, lane16 = 0x8000_0000_0000_0000, Block_last=1, Block_tid=1, all other lanes 0.
- DW=16, TID=1, 68 words with TLAST on the 68th → two blocks.
  - First block: Block_last=0, lanes 0-16 hold the data.
  - Second block: lane0 = 0x06, lane16 = 0x80<<56, Block_last=1.
- DW=16, TID=1, 67 words with TLAST → one block with lane16[63:48] = 0x8006.
- TID=3, 36 words of 0xFFFF with no TLAST → Block_valid after the 36th accept, lanes 0-8 = all ones, lanes 9-24 = 0.
  - Then 1 word with TLAST → next block has lane0 = 0x0006_FFFF and lane8 = 0x80<<56.
- Hold Block_ready=0 for 10 cycles while S_TVALID=1 → S_TREADY=0 throughout, Block unchanged, no words lost.
  - Raising S_TID mid-message leaves Block_tid at the first word's value.
- Assert ARESETn=0 for 1 cycle after 5 words → outputs return to reset values.
  - A new 1-word message then yields only that word plus padding.
